// File: rtl/i2s_rx_deserializer.sv
// I2S line-in receiver: edge-detects sclk/lrclk on line_in_mclk and emits one stereo pair per frame.
// Optional sticky overrun flag/port is built only when I2S_RX_OVERRUN_EN is defined.
module i2s_rx_deserializer #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              line_in_mclk,
  input  logic              rst,
  input  logic              line_in_sclk,
  input  logic              line_in_lrclk,
  input  logic              line_in_sdout,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready
`ifdef I2S_RX_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              sclk_q, sclk_d;
  logic              sclk_q2, sclk_d2;
  logic              lrclk_q, lrclk_d;
  logic              sdout_q, sdout_d;
  logic              ws_last_q, ws_last_d;
  logic              synced_q, synced_d;
  logic              chan_q, chan_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_done_q, left_done_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
`ifdef I2S_RX_OVERRUN_EN
  logic              overrun_q, overrun_d;
`endif

  logic              sclk_rise;
  logic              word_done;
  logic              load;
  logic [DATA_W-1:0] word;

  always_comb begin
    sclk_d      = line_in_sclk;
    sclk_d2     = sclk_q;
    lrclk_d     = line_in_lrclk;
    sdout_d     = line_in_sdout;
    ws_last_d   = ws_last_q;
    synced_d    = synced_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_done_d = left_done_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
`ifdef I2S_RX_OVERRUN_EN
    overrun_d   = overrun_q;
`endif
    sclk_rise = sclk_q & ~sclk_q2;
    word      = {shreg_q[DATA_W-2:0], sdout_q};
    word_done = 1'b0;
    load      = 1'b0;

    if (sclk_rise) begin
      ws_last_d = lrclk_q;
      if (lrclk_q != ws_last_q) begin
        // First bit of a new ws level is the I2S delay slot, not data.
        bit_cnt_d = '0;
        shreg_d   = '0;
        chan_d    = lrclk_q;
        synced_d  = 1'b1;
      end else if (synced_q) begin
        if (bit_cnt_q < CNT_DATA) begin
          shreg_d   = word;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          word_done = (bit_cnt_q == CNT_LAST);
        end else if (bit_cnt_q < CNT_SLOT) begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
    end

    if (word_done) begin
      if (!chan_q) begin
        left_hold_d = word;
        left_done_d = 1'b1;
      end else if (left_done_q) begin
        load        = 1'b1;
        left_done_d = 1'b0;
      end
    end

    // A fresh pair always wins over an accept on the same edge.
    if (load) begin
      left_d  = left_hold_q;
      right_d = word;
      valid_d = 1'b1;
`ifdef I2S_RX_OVERRUN_EN
      overrun_d = overrun_q | (valid_q & ~sample_ready);
`endif
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge line_in_mclk or posedge rst) begin
    if (rst) begin
      sclk_q      <= 1'b0;
      sclk_q2     <= 1'b0;
      lrclk_q     <= 1'b0;
      sdout_q     <= 1'b0;
      ws_last_q   <= 1'b0;
      synced_q    <= 1'b0;
      chan_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_done_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      sclk_q      <= sclk_d;
      sclk_q2     <= sclk_d2;
      lrclk_q     <= lrclk_d;
      sdout_q     <= sdout_d;
      ws_last_q   <= ws_last_d;
      synced_q    <= synced_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_done_q <= left_done_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
`ifdef I2S_RX_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
`ifdef I2S_RX_OVERRUN_EN
  assign overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed + randomized bench: drives mclk/16 I2S frames and checks pairs against the words it sent.
module tb_i2s_rx_deserializer;

  logic        mclk = 1'b0;
  logic        rst;
  logic        sclk, lrclk, sdout, ready;
  logic [23:0] sample_left, sample_right;
  logic        sample_valid;
`ifdef I2S_RX_OVERRUN_EN
  logic        overrun;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard state: pair the bench expects next, and checking modes.
  logic [23:0] exp_l = '0, exp_r = '0;
  bit          hook_pre      = 1'b0;
  bit          quiet         = 1'b0;
  bit          ready_on_load = 1'b0;

  always #5 mclk = ~mclk;

  i2s_rx_deserializer dut (
    .line_in_mclk (mclk),
    .rst          (rst),
    .line_in_sclk (sclk),
    .line_in_lrclk(lrclk),
    .line_in_sdout(sdout),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (ready)
`ifdef I2S_RX_OVERRUN_EN
    ,
    .overrun      (overrun)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [23:0] w, input int i, input int pad);
    if (i >= 1 && i <= 24) return w[24-i];
    if (pad == 0) return 1'b0;
    if (pad == 1) return 1'b1;
    return 1'($urandom & 1);
  endfunction

  // One sclk period (16 mclk), starting at a negedge of mclk.
  task automatic send_bit(input logic ws, input logic d, input bit hook);
    sclk = 1'b0; lrclk = ws; sdout = d;
    repeat (8) @(negedge mclk);
    sclk = 1'b1;
    if (hook) begin
      @(negedge mclk);
      chk("valid_before_load", 32'(sample_valid), 32'(hook_pre));
      if (ready_on_load) ready = 1'b1;
      @(negedge mclk);
      chk("valid_at_load", 32'(sample_valid), 32'd1);
      chk("left_at_load", 32'(sample_left), 32'(exp_l));
      chk("right_at_load", 32'(sample_right), 32'(exp_r));
      @(negedge mclk);
      if (ready) chk("valid_after_accept", 32'(sample_valid), 32'd0);
      else begin
        chk("valid_held", 32'(sample_valid), 32'd1);
        chk("left_held", 32'(sample_left), 32'(exp_l));
        chk("right_held", 32'(sample_right), 32'(exp_r));
      end
      repeat (5) @(negedge mclk);
    end else begin
      repeat (8) @(negedge mclk);
      if (quiet) chk("no_valid", 32'(sample_valid), 32'd0);
    end
  endtask

  task automatic send_slot(input logic ws, input logic [23:0] w, input int pad, input bit hook_lsb);
    for (int i = 0; i < 32; i++)
      send_bit(ws, slot_bit(w, i, pad), hook_lsb && (i == 24));
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int pad, input bit pre);
    send_slot(1'b0, l, pad, 1'b0);
    if (pre) begin
      chk("stable_left", 32'(sample_left), 32'(exp_l));
      chk("stable_right", 32'(sample_right), 32'(exp_r));
    end
    exp_l = l; exp_r = r; hook_pre = pre;
    send_slot(1'b1, r, pad, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] wl, wr;
    rst = 1'b1; sclk = 1'b0; lrclk = 1'b1; sdout = 1'b0; ready = 1'b1;
    repeat (3) @(negedge mclk);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
`ifdef I2S_RX_OVERRUN_EN
    chk("rst_overrun", 32'(overrun), 32'd0);
`endif
    rst = 1'b0;

    // Start mid right slot: nothing until a full left+right frame.
    quiet = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'($urandom & 1), 1'b0);
    send_frame(24'hABCDEF, 24'h123456, 0, 1'b0);

    // Ones in every padding bit must not leak into the words.
    send_frame(24'h800000, 24'h7FFFFF, 1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      wl = 24'($urandom); wr = 24'($urandom);
      send_frame(wl, wr, 2, 1'b0);
    end

    // Stretched right slot far beyond SLOT_W: no spurious words.
    for (int i = 0; i < 100; i++) send_bit(1'b1, 1'($urandom & 1), 1'b0);
    wl = 24'($urandom); wr = 24'($urandom);
    send_frame(wl, wr, 2, 1'b0);

    // Accept on the same edge a new pair loads.
    quiet = 1'b0; ready = 1'b0;
    send_frame(24'h00C0C0, 24'h0C0C00, 2, 1'b0);
    ready_on_load = 1'b1;
    send_frame(24'h0D0D0D, 24'hD0D0D0, 2, 1'b1);
    ready_on_load = 1'b0;
`ifdef I2S_RX_OVERRUN_EN
    chk("overrun_same_edge", 32'(overrun), 32'd0);
`endif

    // Two frames with ready low: newest pair visible.
    ready = 1'b0;
    wl = 24'($urandom); wr = 24'($urandom);
    send_frame(wl, wr, 2, 1'b0);
`ifdef I2S_RX_OVERRUN_EN
    chk("overrun_first", 32'(overrun), 32'd0);
`endif
    wl = 24'($urandom); wr = 24'($urandom);
    send_frame(wl, wr, 2, 1'b1);
`ifdef I2S_RX_OVERRUN_EN
    chk("overrun_set", 32'(overrun), 32'd1);
`endif
    ready = 1'b1;
    @(negedge mclk);
    chk("valid_accepted", 32'(sample_valid), 32'd0);

    // Reset in the middle of a left word.
    wl = 24'($urandom);
    for (int i = 0; i < 10; i++) send_bit(1'b0, slot_bit(wl, i, 0), 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_left", 32'(sample_left), 32'd0);
    chk("midrst_right", 32'(sample_right), 32'd0);
`ifdef I2S_RX_OVERRUN_EN
    chk("midrst_overrun", 32'(overrun), 32'd0);
`endif
    @(negedge mclk); @(negedge mclk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 10; i < 32; i++) send_bit(1'b0, slot_bit(wl, i, 0), 1'b0);
    send_slot(1'b1, 24'($urandom), 2, 1'b0);
    wl = 24'($urandom); wr = 24'($urandom);
    send_frame(wl, wr, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
